// File: rtl/rs_dsp_pkg.sv
// Shared types, default widths and helpers for the rs_dsp MAC family.
// Imported by the MAC top and its reusable output stage.
package rs_dsp_pkg;

  typedef enum logic [1:0] {
    MUL      = 2'd0,
    MAC      = 2'd1,
    MAC_LOAD = 2'd2,
    RSVD     = 2'd3
  } feedback_e;

  localparam int A_WIDTH_DEF     = 20;
  localparam int B_WIDTH_DEF     = 18;
  localparam int ACC_WIDTH_DEF   = 48;
  localparam int OUT_WIDTH_DEF   = 38;
  localparam int SHIFT_WIDTH_DEF = 6;
  localparam int DLY_B_DEF       = 1;

  // Extra product bits so that mixed signed/unsigned operands never overflow.
  localparam int PROD_GUARD  = 2;
  localparam int CLAMP_MAX_W = 64;

  function automatic bit widths_ok(input int a_w, input int b_w, input int acc_w,
                                   input int out_w, input int dly);
    return (acc_w >= a_w + b_w + PROD_GUARD) && (out_w <= acc_w) &&
           (out_w <= CLAMP_MAX_W) && (dly >= 1);
  endfunction

  // Signed bound of a w-bit range, sign-extended to CLAMP_MAX_W bits:
  // neg=0 gives 2^(w-1)-1, neg=1 gives -2^(w-1).
  function automatic logic [CLAMP_MAX_W-1:0] sat_clamp(input int w, input logic neg);
    logic [CLAMP_MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < CLAMP_MAX_W; i++) begin
      v[i] = (i < w - 1) ? ~neg : neg;
    end
    return v;
  endfunction

endpackage

// File: rtl/rs_dsp_out_stage.sv
// Combinational round / arithmetic shift / saturate stage that feeds the
// output register of the MAC; shared with the cascade wrapper.
module rs_dsp_out_stage
  import rs_dsp_pkg::*;
#(
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SHIFT_WIDTH-1:0] shift_right,
  input  logic                   round,
  input  logic                   saturate_enable,
  output logic [OUT_WIDTH-1:0]   z,
  output logic                   sat
);

  localparam int RW = ACC_WIDTH + 1;

  logic [31:0]          s_amt;
  logic [RW-1:0]        rnd_add;
  logic [RW-1:0]        r;
  logic [RW-1:0]        q;
  logic [OUT_WIDTH-1:0] trunc;
  logic [RW-1:0]        q_back;
  logic                 fits;

  always_comb begin
    s_amt   = (32'(shift_right) > 32'(ACC_WIDTH - 1)) ? 32'(ACC_WIDTH - 1) : 32'(shift_right);
    rnd_add = (round && (s_amt != 32'd0)) ? (RW'(1) << (s_amt - 32'd1)) : '0;
    // One guard bit keeps the rounding carry from flipping the sign.
    r       = {acc[ACC_WIDTH-1], acc} + rnd_add;
    q       = RW'($signed(r) >>> s_amt);
    trunc   = q[OUT_WIDTH-1:0];
    q_back  = {{(RW - OUT_WIDTH){trunc[OUT_WIDTH-1]}}, trunc};
    fits    = (q_back == q);
    sat     = ~fits;
    z       = (saturate_enable && !fits) ? OUT_WIDTH'(sat_clamp(OUT_WIDTH, q[RW-1])) : trunc;
  end

endmodule

// File: rtl/rs_dsp_mac.sv
// Four-stage pipelined multiply-accumulate: input register, multiply,
// accumulate, round/shift/saturate output register, plus a B cascade chain.
module rs_dsp_mac
  import rs_dsp_pkg::*;
#(
  parameter int A_WIDTH      = A_WIDTH_DEF,
  parameter int B_WIDTH      = B_WIDTH_DEF,
  parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
  parameter int SHIFT_WIDTH  = SHIFT_WIDTH_DEF,
  parameter int DLY_B_STAGES = DLY_B_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [A_WIDTH-1:0]     a_i,
  input  logic [B_WIDTH-1:0]     b_i,
  input  logic                   unsigned_a,
  input  logic                   unsigned_b,
  input  logic [1:0]             feedback,
  input  logic                   load_acc,
  input  logic [ACC_WIDTH-1:0]   acc_load_i,
  input  logic                   subtract,
  input  logic [SHIFT_WIDTH-1:0] shift_right,
  input  logic                   round,
  input  logic                   saturate_enable,
  output logic                   valid_o,
  output logic [OUT_WIDTH-1:0]   z_o,
  output logic                   sat_o,
  output logic [B_WIDTH-1:0]     dly_b_o
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH + PROD_GUARD;

  if (!widths_ok(A_WIDTH, B_WIDTH, ACC_WIDTH, OUT_WIDTH, DLY_B_STAGES)) begin : g_width_check
    $error("rs_dsp_mac: illegal width parameters");
  end

  // Valid-only pipeline, no backpressure: each stage's vN marks that its
  // registers hold a live sample; data registers hold while vN is low.

  // S1: input register
  logic                   v1;
  logic [A_WIDTH-1:0]     a1;
  logic [B_WIDTH-1:0]     b1;
  logic                   ua1, ub1, load1, sub1, rnd1, sen1;
  feedback_e              fb1;
  logic [ACC_WIDTH-1:0]   pre1;
  logic [SHIFT_WIDTH-1:0] sh1;

  always_ff @(posedge clock) begin
    if (reset) begin
      v1    <= 1'b0;
      a1    <= '0;
      b1    <= '0;
      ua1   <= 1'b0;
      ub1   <= 1'b0;
      fb1   <= MUL;
      load1 <= 1'b0;
      pre1  <= '0;
      sub1  <= 1'b0;
      sh1   <= '0;
      rnd1  <= 1'b0;
      sen1  <= 1'b0;
    end else begin
      v1 <= valid_i;
      if (valid_i) begin
        a1    <= a_i;
        b1    <= b_i;
        ua1   <= unsigned_a;
        ub1   <= unsigned_b;
        fb1   <= feedback_e'(feedback);
        load1 <= load_acc;
        pre1  <= acc_load_i;
        sub1  <= subtract;
        sh1   <= shift_right;
        rnd1  <= round;
        sen1  <= saturate_enable;
      end
    end
  end

  // S2: multiply
  logic signed [P_WIDTH-1:0] a_ext, b_ext, prod;

  always_comb begin
    a_ext = P_WIDTH'($signed({~ua1 & a1[A_WIDTH-1], a1}));
    b_ext = P_WIDTH'($signed({~ub1 & b1[B_WIDTH-1], b1}));
    prod  = a_ext * b_ext;
  end

  logic                   v2;
  logic [ACC_WIDTH-1:0]   p2, pre2;
  feedback_e              fb2;
  logic                   load2, sub2, rnd2, sen2;
  logic [SHIFT_WIDTH-1:0] sh2;

  always_ff @(posedge clock) begin
    if (reset) begin
      v2    <= 1'b0;
      p2    <= '0;
      pre2  <= '0;
      fb2   <= MUL;
      load2 <= 1'b0;
      sub2  <= 1'b0;
      sh2   <= '0;
      rnd2  <= 1'b0;
      sen2  <= 1'b0;
    end else begin
      v2 <= v1;
      if (v1) begin
        p2    <= ACC_WIDTH'(prod);
        pre2  <= pre1;
        fb2   <= fb1;
        load2 <= load1;
        sub2  <= sub1;
        sh2   <= sh1;
        rnd2  <= rnd1;
        sen2  <= sen1;
      end
    end
  end

  // S3: accumulate; the reserved mode falls through to the MUL base.
  logic                   v3;
  logic [ACC_WIDTH-1:0]   acc, base, acc_next;
  logic [SHIFT_WIDTH-1:0] sh3;
  logic                   rnd3, sen3;

  always_comb begin
    base = '0;
    case (fb2)
      MAC:      base = load2 ? '0 : acc;
      MAC_LOAD: base = load2 ? pre2 : acc;
      default:  base = '0;
    endcase
    acc_next = sub2 ? (base - p2) : (base + p2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v3   <= 1'b0;
      acc  <= '0;
      sh3  <= '0;
      rnd3 <= 1'b0;
      sen3 <= 1'b0;
    end else begin
      v3 <= v2;
      if (v2) begin
        acc  <= acc_next;
        sh3  <= sh2;
        rnd3 <= rnd2;
        sen3 <= sen2;
      end
    end
  end

  // S4: output register
  logic [OUT_WIDTH-1:0] z_next;
  logic                 sat_next;

  rs_dsp_out_stage #(
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH)
  ) u_out_stage (
    .acc            (acc),
    .shift_right    (sh3),
    .round          (rnd3),
    .saturate_enable(sen3),
    .z              (z_next),
    .sat            (sat_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_o <= 1'b0;
      z_o     <= '0;
      sat_o   <= 1'b0;
    end else begin
      valid_o <= v3;
      if (v3) begin
        z_o   <= z_next;
        sat_o <= sat_next;
      end
    end
  end

  // B cascade chain, advanced only by accepted samples.
  logic [B_WIDTH-1:0] dly_q [DLY_B_STAGES];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DLY_B_STAGES; i++) dly_q[i] <= '0;
    end else if (valid_i) begin
      dly_q[0] <= b_i;
      for (int i = 1; i < DLY_B_STAGES; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dly_b_o = dly_q[DLY_B_STAGES-1];

endmodule

// File: tb/tb_rs_dsp_mac.sv
// Self-checking bench for rs_dsp_mac: arithmetic reference model feeding an
// expected queue, a per-cycle compare process and literal pins on key results.
module tb_rs_dsp_mac;

  localparam int DLY = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        valid_i = 1'b0;
  logic [19:0] a_i = '0;
  logic [17:0] b_i = '0;
  logic        unsigned_a = 1'b0, unsigned_b = 1'b0;
  logic [1:0]  feedback = 2'd0;
  logic        load_acc = 1'b0;
  logic [47:0] acc_load_i = '0;
  logic        subtract = 1'b0;
  logic [5:0]  shift_right = '0;
  logic        round = 1'b0, saturate_enable = 1'b0;
  logic        valid_o;
  logic [37:0] z_o;
  logic        sat_o;
  logic [17:0] dly_b_o;

  rs_dsp_mac dut (
    .clock(clock), .reset(reset), .valid_i(valid_i), .a_i(a_i), .b_i(b_i),
    .unsigned_a(unsigned_a), .unsigned_b(unsigned_b), .feedback(feedback),
    .load_acc(load_acc), .acc_load_i(acc_load_i), .subtract(subtract),
    .shift_right(shift_right), .round(round), .saturate_enable(saturate_enable),
    .valid_o(valid_o), .z_o(z_o), .sat_o(sat_o), .dly_b_o(dly_b_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] cyc;
    logic [37:0] z;
    logic        sat;
    logic        has_lit;
    logic [37:0] lit_z;
    logic        lit_sat;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] b_hist[$];
  logic [47:0] acc_m = '0;
  bit          armed = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clock) begin
    exp_t        e;
    logic        exp_valid;
    logic [17:0] exp_dly;
    #1;
    if (armed) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missed_output", 64'(1), 64'(0));
      end
      exp_valid = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
      chk("valid_o", 64'(valid_o), 64'(exp_valid));
      if (exp_valid) begin
        e = exp_q.pop_front();
        chk("z_o", 64'(z_o), 64'(e.z));
        chk("sat_o", 64'(sat_o), 64'(e.sat));
        if (e.has_lit) begin
          chk("z_o_literal", 64'(z_o), 64'(e.lit_z));
          chk("sat_o_literal", 64'(sat_o), 64'(e.lit_sat));
        end
      end
      exp_dly = (b_hist.size() >= DLY) ? b_hist[DLY-1] : '0;
      chk("dly_b_o", 64'(dly_b_o), 64'(exp_dly));
    end
  end

  // ---------------- reference model + driver ----------------
  task automatic send(input logic [19:0] a, input logic [17:0] b, input logic [1:0] fb,
                      input logic load, input logic [47:0] pre, input logic sub,
                      input logic [5:0] sh, input logic rnd, input logic sen,
                      input logic ua, input logic ub,
                      input logic has_lit, input logic [37:0] lit_z, input logic lit_sat);
    longint ae, be, pr, base, accs, r, q, hi, lo;
    int     s;
    logic   oor;
    exp_t   e;
    @(negedge clock);
    valid_i = 1'b1; a_i = a; b_i = b; feedback = fb; load_acc = load; acc_load_i = pre;
    subtract = sub; shift_right = sh; round = rnd; saturate_enable = sen;
    unsigned_a = ua; unsigned_b = ub;

    ae = ua ? longint'(a) : longint'($signed(a));
    be = ub ? longint'(b) : longint'($signed(b));
    pr = ae * be;
    accs = longint'($signed(acc_m));
    if (fb == 2'd1)      base = load ? 64'sd0 : accs;
    else if (fb == 2'd2) base = load ? longint'($signed(pre)) : accs;
    else                 base = 0;
    acc_m = 48'(sub ? base - pr : base + pr);

    accs = longint'($signed(acc_m));
    s    = (sh > 6'd47) ? 47 : int'(sh);
    r    = accs + ((rnd && s > 0) ? (longint'(1) <<< (s - 1)) : 64'sd0);
    q    = r >>> s;
    hi   = (longint'(1) <<< 37) - 1;
    lo   = -(longint'(1) <<< 37);
    oor  = (q > hi) || (q < lo);
    e.cyc = cyc + 4;
    if (sen && oor) e.z = (q > hi) ? hi[37:0] : lo[37:0];
    else            e.z = q[37:0];
    e.sat     = oor;
    e.has_lit = has_lit;
    e.lit_z   = lit_z;
    e.lit_sat = lit_sat;
    exp_q.push_back(e);
    b_hist.push_front(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      valid_i = 1'b0;
      a_i = 20'($urandom); b_i = 18'($urandom);
      feedback = 2'($urandom_range(0, 3)); load_acc = 1'($urandom_range(0, 1));
      subtract = 1'($urandom_range(0, 1)); shift_right = 6'($urandom_range(0, 63));
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b1; valid_i = 1'b0;
    exp_q.delete(); b_hist.delete(); acc_m = '0;
    repeat (n) @(negedge clock);
    chk("reset_z_o", 64'(z_o), 64'(0));
    chk("reset_sat_o", 64'(sat_o), 64'(0));
    chk("reset_valid_o", 64'(valid_o), 64'(0));
    chk("reset_dly_b_o", 64'(dly_b_o), 64'(0));
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [47:0] rpre;
    repeat (3) @(negedge clock);
    armed = 1'b1;
    do_reset(1);

    // MUL signed
    send(20'(-3), 18'd7, 2'd0, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'(-21), 1'b0);
    idle(5);

    // MAC chain, back-to-back
    send(20'd2, 18'd3, 2'd1, 1'b1, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd6, 1'b0);
    send(20'd4, 18'd5, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd26, 1'b0);
    send(20'd1, 18'd1, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd27, 1'b0);
    send(20'd2, 18'd2, 2'd1, 1'b0, '0, 1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd23, 1'b0);
    idle(2);

    // MAC_LOAD, bubble, then accumulator must still hold 1100
    send(20'd10, 18'd10, 2'd2, 1'b1, 48'd1000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd1100, 1'b0);
    idle(1);
    send(20'd0, 18'd0, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd1100, 1'b0);
    idle(3);

    // Round / shift
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'd13, 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 38'd3, 1'b0);
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'd13, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd3, 1'b0);
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'(-13), 1'b0, 6'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 38'(-3), 1'b0);
    // Shift amount above ACC_WIDTH-1 clamps to 47
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'(-5), 1'b0, 6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'(-1), 1'b0);
    idle(2);

    // Saturation both bounds, then truncation
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'h010000000000, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 38'h1FFFFFFFFF, 1'b1);
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'h010000000000, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd0, 1'b1);
    send(20'd0, 18'd0, 2'd2, 1'b1, 48'hFF0000000000, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 38'h2000000000, 1'b1);
    idle(2);

    // Operand extension and reserved mode
    send(20'hFFFFF, 18'h3FFFF, 2'd0, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 38'(-1048575), 1'b0);
    send(20'hFFFFF, 18'h3FFFF, 2'd0, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    send(20'd3, 18'd4, 2'd3, 1'b1, 48'd555, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd12, 1'b0);
    idle(5);

    // Reset mid-pipeline: three in flight, none may emerge
    send(20'd5, 18'd5, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send(20'd6, 18'd6, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    send(20'd7, 18'd7, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    do_reset(1);
    idle(4);
    send(20'd2, 18'd2, 2'd1, 1'b0, '0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 38'd4, 1'b0);
    idle(5);

    // Mixed-control tail with bubbles
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        rpre = {16'($urandom), 32'($urandom)};
        send(20'($urandom), 18'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             rpre, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'b0, '0, 1'b0);
      end
    end
    idle(8);
    chk("drain_queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
